// File: rtl/heartaware_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | heartaware_pkg                                                       |
// | Shared types and constants for the pulse period measurement path.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package heartaware_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } meter_state_t;

    localparam int unsigned c_cnt_w_default = 32;

    // Heartbeat limits at the 50 MHz board clock: 300 bpm floor, 30 bpm ceiling.
    localparam int unsigned c_board_clk_hz  = 50_000_000;
    localparam int unsigned c_min_period_hb = c_board_clk_hz / 5;
    localparam int unsigned c_max_period_hb = c_board_clk_hz * 2;

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_rise_detect                                                     |
// | Multi-flop synchronizer followed by a rising-edge detector.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pulse_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_period_meter                                                   |
// | Counts clk cycles between rising edges of an asynchronous pulse.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pulse_period_meter
    import heartaware_pkg::*;
#(
    parameter int unsigned      CNT_W       = c_cnt_w_default,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] MIN_PERIOD  = CNT_W'(4),
    parameter logic [CNT_W-1:0] MAX_PERIOD  = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             measuring
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic w_rise;

    meter_state_t     r_state,   w_state_next;
    logic [CNT_W-1:0] r_cnt,     w_cnt_next;
    logic [CNT_W-1:0] r_period,  w_period_next;
    logic             r_valid,   w_valid_next;
    logic             r_timeout, w_timeout_next;
    logic             r_measuring;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_rise (
        .clk      (clk),
        .reset    (reset),
        .async_in (pulse_in),
        .rise     (w_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_period    <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_measuring <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_period    <= w_period_next;
            r_valid     <= w_valid_next;
            r_timeout   <= w_timeout_next;
            r_measuring <= (w_state_next == ST_MEASURE);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_period_next  = r_period;
        w_valid_next   = 1'b0;
        w_timeout_next = r_timeout;

        if (!enable) begin
            w_state_next   = ST_IDLE;
            w_timeout_next = 1'b0;
            w_cnt_next     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_cnt_next   = c_cnt_one;
                        w_state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // An edge on the MAX_PERIOD cycle is still a valid period.
                    if (w_rise && (r_cnt >= MIN_PERIOD)) begin
                        w_period_next = r_cnt;
                        w_valid_next  = 1'b1;
                        w_cnt_next    = c_cnt_one;
                    end else if (r_cnt == MAX_PERIOD) begin
                        w_state_next   = ST_TIMEOUT;
                        w_timeout_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    if (w_rise) begin
                        w_timeout_next = 1'b0;
                        w_cnt_next     = c_cnt_one;
                        w_state_next   = ST_MEASURE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_valid;
    assign timeout      = r_timeout;
    assign measuring    = r_measuring;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pulse_period_meter                                                |
// | Randomized scoreboard bench for pulse_period_meter.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pulse_period_meter;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_P       = 4;
    localparam int MAX_P       = 100;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             enable   = 1'b0;
    logic             pulse_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             timeout;
    logic             measuring;

    pulse_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_PERIOD  (16'(MIN_P)),
        .MAX_PERIOD  (16'(MAX_P))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .timeout      (timeout),
        .measuring    (measuring)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int period;
        int drive_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total          = 0;
    int   bad            = 0;
    int   timeout_cycles = 0;
    int   tc0            = 0;

    // Reference model: edge times in cycles, interval rules applied directly.
    bit m_armed  = 1'b0;
    int m_last   = 0;
    int m_period = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input int t);
        int d;
        if (!m_armed) begin
            m_armed = 1'b1;
            m_last  = t;
        end else begin
            d = t - m_last;
            if (d > MAX_P) begin
                m_last = t;
            end else if (d >= MIN_P) begin
                sb_q.push_back('{period: d, drive_cyc: t});
                m_period = d;
                m_last   = t;
            end
        end
    endtask

    // One rising edge now, next edge exactly gap cycles later.
    task automatic send(input int gap);
        int w;
        w = (gap >= 4) ? 2 : 1;
        model_edge(cyc);
        pulse_in = 1'b1;
        repeat (w) tick();
        pulse_in = 1'b0;
        repeat (gap - w) tick();
    endtask

    task automatic quiet(input int n);
        repeat (n) tick();
    endtask

    initial begin : monitor
        bit prev_valid;
        int lat;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (timeout) timeout_cycles++;
            if (period_valid) begin
                check("strobe_gap", int'(prev_valid), 0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: period_out=%0d, none expected (cycle %0d)",
                             period_out, cyc);
                end else begin
                    e   = sb_q.pop_front();
                    lat = cyc - e.drive_cyc;
                    check("period", int'(period_out), e.period);
                    if (lat < 2 || lat > SYNC_STAGES + 3) begin
                        total++;
                        bad++;
                        $display("FAIL latency: got %0d cycles expected 2..%0d", lat, SYNC_STAGES + 3);
                    end else begin
                        total++;
                    end
                end
            end
            prev_valid = period_valid;
        end
    end

    initial begin : stimulus
        quiet(2);
        check("reset_period", int'(period_out), 0);
        check("reset_valid", int'(period_valid), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_measuring", int'(measuring), 0);
        reset  = 1'b0;
        enable = 1'b1;
        quiet(3);

        // Steady train
        repeat (5) send(50);
        check("steady_measuring", int'(measuring), 1);
        check("steady_timeout", int'(timeout), 0);

        // Glitch two cycles after an accepted edge
        send(2);
        send(48);
        send(50);

        // Lost signal, then recovery
        send(150);
        check("to_level", int'(timeout), 1);
        check("to_measuring", int'(measuring), 0);
        check("to_period_hold", int'(period_out), m_period);
        send(30);
        check("to_cleared", int'(timeout), 0);
        check("to_rearm_measuring", int'(measuring), 1);
        send(30);

        // MAX_PERIOD boundary and MIN_PERIOD boundary
        tc0 = timeout_cycles;
        send(100);
        send(100);
        send(101);
        check("max_no_timeout", timeout_cycles - tc0, 0);
        send(4);
        check("over_max_timeout_seen", int'(timeout_cycles > tc0), 1);
        send(60);
        send(3);
        send(50);

        // Reset in the middle of a measurement
        send(40);
        reset = 1'b1;
        tick();
        check("midreset_period", int'(period_out), 0);
        check("midreset_valid", int'(period_valid), 0);
        check("midreset_timeout", int'(timeout), 0);
        check("midreset_measuring", int'(measuring), 0);
        reset    = 1'b0;
        m_armed  = 1'b0;
        m_period = 0;
        quiet(3);
        send(20);
        send(20);

        // Enable dropped mid-measurement
        enable  = 1'b0;
        m_armed = 1'b0;
        quiet(10);
        check("dis_measuring", int'(measuring), 0);
        check("dis_period_hold", int'(period_out), m_period);
        check("dis_timeout", int'(timeout), 0);
        enable = 1'b1;
        quiet(3);
        send(25);
        send(25);
        send(5);

        // Random intervals spanning glitch, normal and timeout ranges
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(2, 130)));
        end
        quiet(10);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
